// File: rtl/spi_sclk_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_sclk_engine                                              |
// | Description : SPI serial-clock engine. Runs one chip-select framed         |
// |               transfer per go pulse, generating SCLK in all four           |
// |               CPOL/CPHA modes, one-cycle edge pulses and the sample/shift  |
// |               strobes that drive the shift-register datapath.              |
// | Optional    : SPI_SCLK_DLY_EN - adds SETUP/HOLD states that extend CS      |
// |               setup and hold by dly+1 cycles each. When undefined, the dly |
// |               port is present but ignored.                                 |
// | Ports       : clk_in, rst (async, active-high)                             |
// |               go, cpol, cpha, divider, nbits, dly  - request and config    |
// |               sclk, cs_n                           - SPI pins              |
// |               pos_edge, neg_edge, sample, shift    - datapath strobes      |
// |               busy, done                           - status                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_sclk_engine #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 7,
  parameter int DLY_W = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             go,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [DIV_W-1:0] divider,
  input  logic [CNT_W-1:0] nbits,
  input  logic [DLY_W-1:0] dly,
  output logic             sclk,
  output logic             cs_n,
  output logic             pos_edge,
  output logic             neg_edge,
  output logic             sample,
  output logic             shift,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd2;
`ifdef SPI_SCLK_DLY_EN
  localparam logic [1:0] c_SETUP = 2'd1;
  localparam logic [1:0] c_HOLD  = 2'd3;
`endif

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;

  // Transfer configuration captured at go
  logic             r_cpol;
  logic             r_cpha;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W:0]   r_nbits;   // effective length, 0 already mapped to 2**CNT_W

  logic [DIV_W-1:0] r_hcnt;    // half-period down-counter
  logic [CNT_W:0]   r_bit;     // completed bits (one extra bit avoids wrap)
  logic             r_trail;   // next edge is the trailing edge of a bit

`ifdef SPI_SCLK_DLY_EN
  logic [DLY_W-1:0] r_dly;
  logic [DLY_W-1:0] r_dcnt;
`else
  logic             w_unused_dly;
  assign w_unused_dly = ^dly;
`endif

  logic             w_tick;
  logic             w_last;
  logic             w_edge;
  logic [CNT_W:0]   w_bit_inc;

  logic             w_sclk_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_pos_nxt;
  logic             w_neg_nxt;
  logic             w_sample_nxt;
  logic             w_shift_nxt;

  assign w_tick    = (r_hcnt == '0);
  // All 2N edges have been issued once every bit has completed
  assign w_last    = (r_bit == r_nbits);
  assign w_edge    = (r_state == c_RUN) && w_tick && !w_last;
  assign w_bit_inc = r_bit + 1'b1;

  // State register
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
`ifdef SPI_SCLK_DLY_EN
        if (go) w_state_nxt = c_SETUP;
`else
        if (go) w_state_nxt = c_RUN;
`endif
      end
`ifdef SPI_SCLK_DLY_EN
      c_SETUP: if (r_dcnt == '0) w_state_nxt = c_RUN;
      c_RUN:   if (w_tick && w_last) w_state_nxt = c_HOLD;
      c_HOLD:  if (r_dcnt == '0) w_state_nxt = c_IDLE;
`else
      c_RUN:   if (w_tick && w_last) w_state_nxt = c_IDLE;
`endif
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    w_busy_nxt = (w_state_nxt != c_IDLE);
    w_done_nxt = (r_state != c_IDLE) && (w_state_nxt == c_IDLE);
    w_sclk_nxt = r_sclk_q();
    case (r_state)
      c_IDLE: w_sclk_nxt = cpol;
      c_RUN: begin
        if (w_edge) begin
          w_sclk_nxt = ~sclk;
        end else if (w_tick) begin
          w_sclk_nxt = r_cpol;
        end
      end
      default: w_sclk_nxt = r_cpol;
    endcase
    w_pos_nxt    = w_edge && !sclk;
    w_neg_nxt    = w_edge &&  sclk;
    // Leading edges sample in mode cpha=0, trailing edges sample in cpha=1
    w_sample_nxt = w_edge && (r_trail == r_cpha);
    // cpha=0 launches on trailing edges except the final one, since bit 0
    // was preloaded at go; cpha=1 launches on every leading edge.
    w_shift_nxt  = w_edge && (r_cpha ? !r_trail
                                     : (r_trail && (w_bit_inc != r_nbits)));
  end

  function automatic logic r_sclk_q();
    return sclk;
  endfunction

  // Output registers
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      pos_edge <= 1'b0;
      neg_edge <= 1'b0;
      sample   <= 1'b0;
      shift    <= 1'b0;
    end else begin
      sclk     <= w_sclk_nxt;
      cs_n     <= ~w_busy_nxt;
      busy     <= w_busy_nxt;
      done     <= w_done_nxt;
      pos_edge <= w_pos_nxt;
      neg_edge <= w_neg_nxt;
      sample   <= w_sample_nxt;
      shift    <= w_shift_nxt;
    end
  end

  // Datapath: configuration capture, half-period and bit counters
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cpol  <= 1'b0;
      r_cpha  <= 1'b0;
      r_div   <= '0;
      r_nbits <= '0;
      r_hcnt  <= '0;
      r_bit   <= '0;
      r_trail <= 1'b0;
`ifdef SPI_SCLK_DLY_EN
      r_dly   <= '0;
      r_dcnt  <= '0;
`endif
    end else begin
      case (r_state)
        c_IDLE: begin
          if (go) begin
            r_cpol  <= cpol;
            r_cpha  <= cpha;
            r_div   <= divider;
            r_nbits <= {(nbits == '0), nbits};
            r_hcnt  <= divider;
            r_bit   <= '0;
            r_trail <= 1'b0;
`ifdef SPI_SCLK_DLY_EN
            r_dly   <= dly;
            r_dcnt  <= dly;
`endif
          end
        end
`ifdef SPI_SCLK_DLY_EN
        c_SETUP: if (r_dcnt != '0) r_dcnt <= r_dcnt - 1'b1;
        c_HOLD:  if (r_dcnt != '0) r_dcnt <= r_dcnt - 1'b1;
`endif
        c_RUN: begin
          if (w_tick) begin
            r_hcnt <= r_div;
            if (!w_last) begin
              r_trail <= ~r_trail;
              if (r_trail) r_bit <= w_bit_inc;
            end
`ifdef SPI_SCLK_DLY_EN
            else begin
              r_dcnt <= r_dly;
            end
`endif
          end else begin
            r_hcnt <= r_hcnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
